// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared states, opcode/funct constants and datapath select encodings
package mcpu_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE,
    ALU_WB, BRANCH, JUMP, IMM_EXEC, IMM_WB, TRAP
  } state_t;
  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_IMM} alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_v2_if.sv
// multicycle_ctrl_v2_if: instruction/status inputs and datapath enables of the controller
interface multicycle_ctrl_v2_if #(parameter int ALUCTL_W = 3);
  logic [5:0] Op;
  logic [5:0] funct;
  logic Zero;
  logic MemReady;
  logic PCEn;
  logic IorD;
  logic MemRead;
  logic MemWrite;
  logic IRWrite;
  logic RegWrite;
  logic RegDst;
  logic MemtoReg;
  logic ALUSrcA;
  logic [1:0] ALUSrcB;
  logic ImmZeroExt;
  logic [1:0] PCSource;
  logic [ALUCTL_W-1:0] aluControl;
  logic Illegal;
  modport master (
    input Op, funct, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ImmZeroExt, PCSource, aluControl, Illegal
  );
  modport slave (
    output Op, funct, Zero, MemReady,
    input PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
          ALUSrcA, ALUSrcB, ImmZeroExt, PCSource, aluControl, Illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALU op class plus funct/Op to an ALU control code and a valid flag
import mcpu_pkg::*;
module alu_decoder (
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  input  logic [5:0] op,
  output logic [2:0] alu_ctl,
  output logic       valid
);
  always_comb begin
    alu_ctl = ALU_ADD;
    valid = 1'b1;
    case (alu_op)
      AOP_SUB: alu_ctl = ALU_SUB;
      AOP_FUNCT:
        case (funct)
          FN_ADD: alu_ctl = ALU_ADD;
          FN_SUB: alu_ctl = ALU_SUB;
          FN_AND: alu_ctl = ALU_AND;
          FN_OR:  alu_ctl = ALU_OR;
          FN_XOR: alu_ctl = ALU_XOR;
          FN_NOR: alu_ctl = ALU_NOR;
          FN_SLT: alu_ctl = ALU_SLT;
          default: valid = 1'b0;
        endcase
      AOP_IMM:
        case (op)
          OP_ADDI: alu_ctl = ALU_ADD;
          OP_SLTI: alu_ctl = ALU_SLT;
          OP_ANDI: alu_ctl = ALU_AND;
          OP_ORI:  alu_ctl = ALU_OR;
          OP_XORI: alu_ctl = ALU_XOR;
          default: valid = 1'b0;
        endcase
      default: alu_ctl = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl_v2.sv
// multicycle_ctrl_v2: multicycle MIPS control FSM with memory-ready timeout and illegal-instruction trap
import mcpu_pkg::*;
module multicycle_ctrl_v2 #(
  parameter int ALUCTL_W = 3,
  parameter int MEM_HANDSHAKE = 1,
  parameter int WAIT_LIMIT = 15
) (
  input logic Clk,
  input logic Reset,
  multicycle_ctrl_v2_if.master bus
);
  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  alu_op_t aop;
  logic [2:0] dec_ctl;
  logic dec_valid;
  logic ready, tmo;
  logic [ALUCTL_W-1:0] ctl;
  assign ready = (MEM_HANDSHAKE != 0) ? bus.MemReady : 1'b1;
  assign tmo = (WAIT_LIMIT != 0) && (cnt == CW'(WAIT_LIMIT));
  assign aop = state == EXECUTE ? AOP_FUNCT : state == IMM_EXEC ? AOP_IMM : state == BRANCH ? AOP_SUB : AOP_ADD;
  assign ctl = ALUCTL_W'(dec_ctl);
  alu_decoder u_dec (.alu_op(aop), .funct(bus.funct), .op(bus.Op), .alu_ctl(dec_ctl), .valid(dec_valid));
  // MemReady beats the timeout when both land in the same cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FETCH;
      cnt <= '0;
    end else begin
      cnt <= '0;
      case (state)
        FETCH, MEM_READ, MEM_WRITE:
          if (ready) state <= state == FETCH ? DECODE : state == MEM_READ ? MEM_WB : FETCH;
          else if (tmo) state <= TRAP;
          else cnt <= cnt + 1'b1;
        DECODE:
          case (bus.Op)
            OP_LW, OP_SW: state <= MEM_ADDR;
            OP_RTYPE: state <= EXECUTE;
            OP_BEQ, OP_BNE: state <= BRANCH;
            OP_J: state <= JUMP;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state <= IMM_EXEC;
            default: state <= TRAP;
          endcase
        MEM_ADDR: state <= bus.Op == OP_SW ? MEM_WRITE : MEM_READ;
        EXECUTE: state <= dec_valid ? ALU_WB : TRAP;
        IMM_EXEC: state <= IMM_WB;
        TRAP: state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end
  always_comb begin
    bus.PCEn = 1'b0;
    bus.IorD = 1'b0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.RegDst = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.ALUSrcA = 1'b0;
    bus.ALUSrcB = SRCB_B;
    bus.ImmZeroExt = 1'b0;
    bus.PCSource = PC_ALU;
    bus.aluControl = '0;
    bus.Illegal = 1'b0;
    if (!Reset)
      case (state)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = SRCB_4;
          bus.aluControl = ctl;
          bus.IRWrite = ready;
          bus.PCEn = ready;
        end
        DECODE: begin
          bus.ALUSrcB = SRCB_IMM2;
          bus.aluControl = ctl;
        end
        MEM_ADDR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
          bus.aluControl = ctl;
        end
        MEM_READ: begin
          bus.MemRead = 1'b1;
          bus.IorD = 1'b1;
        end
        MEM_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        MEM_WRITE: begin
          bus.MemWrite = 1'b1;
          bus.IorD = 1'b1;
        end
        EXECUTE: begin
          bus.ALUSrcA = 1'b1;
          bus.aluControl = ctl;
        end
        ALU_WB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcA = 1'b1;
          bus.aluControl = ctl;
          bus.PCSource = PC_ALUOUT;
          bus.PCEn = bus.Op == OP_BNE ? !bus.Zero : bus.Zero;
        end
        JUMP: begin
          bus.PCSource = PC_JUMP;
          bus.PCEn = 1'b1;
        end
        IMM_EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
          bus.aluControl = ctl;
          bus.ImmZeroExt = bus.Op == OP_ANDI || bus.Op == OP_ORI || bus.Op == OP_XORI;
        end
        IMM_WB: bus.RegWrite = 1'b1;
        TRAP: bus.Illegal = 1'b1;
        default: bus.Illegal = 1'b0;
      endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// tb_multicycle_ctrl_v2: table-driven cycle-by-cycle check of the controller plus timeout sequences
module tb_multicycle_ctrl_v2;
  logic clk = 1'b0;
  logic rst;
  int n = 0;
  int fails = 0;
  always #5 clk = ~clk;
  multicycle_ctrl_v2_if #(.ALUCTL_W(3)) bus ();
  multicycle_ctrl_v2 #(.ALUCTL_W(3), .MEM_HANDSHAKE(1), .WAIT_LIMIT(15)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  // field order: PCEn IorD MemRead MemWrite IRWrite RegWrite RegDst MemtoReg ALUSrcA ALUSrcB ImmZeroExt PCSource aluControl Illegal
  logic [17:0] act;
  assign act = {bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg,
                bus.ALUSrcA, bus.ALUSrcB, bus.ImmZeroExt, bus.PCSource, bus.aluControl, bus.Illegal};
  localparam logic [17:0] E_ZERO  = 18'd0;
  localparam logic [17:0] E_FRDY  = 18'b1_0_1_0_1_0_0_0_0_01_0_00_010_0;
  localparam logic [17:0] E_FWAIT = 18'b0_0_1_0_0_0_0_0_0_01_0_00_010_0;
  localparam logic [17:0] E_DEC   = 18'b0_0_0_0_0_0_0_0_0_11_0_00_010_0;
  localparam logic [17:0] E_MADDR = 18'b0_0_0_0_0_0_0_0_1_10_0_00_010_0;
  localparam logic [17:0] E_MRD   = 18'b0_1_1_0_0_0_0_0_0_00_0_00_000_0;
  localparam logic [17:0] E_MWB   = 18'b0_0_0_0_0_1_0_1_0_00_0_00_000_0;
  localparam logic [17:0] E_MWR   = 18'b0_1_0_1_0_0_0_0_0_00_0_00_000_0;
  localparam logic [17:0] E_EXADD = 18'b0_0_0_0_0_0_0_0_1_00_0_00_010_0;
  localparam logic [17:0] E_EXBAD = 18'b0_0_0_0_0_0_0_0_1_00_0_00_000_0;
  localparam logic [17:0] E_AWB   = 18'b0_0_0_0_0_1_1_0_0_00_0_00_000_0;
  localparam logic [17:0] E_BRT   = 18'b1_0_0_0_0_0_0_0_1_00_0_01_110_0;
  localparam logic [17:0] E_BRN   = 18'b0_0_0_0_0_0_0_0_1_00_0_01_110_0;
  localparam logic [17:0] E_JMP   = 18'b1_0_0_0_0_0_0_0_0_00_0_10_000_0;
  localparam logic [17:0] E_ORI   = 18'b0_0_0_0_0_0_0_0_1_10_1_00_001_0;
  localparam logic [17:0] E_SLTI  = 18'b0_0_0_0_0_0_0_0_1_10_0_00_111_0;
  localparam logic [17:0] E_IWB   = 18'b0_0_0_0_0_1_0_0_0_00_0_00_000_0;
  localparam logic [17:0] E_TRAP  = 18'b0_0_0_0_0_0_0_0_0_00_0_00_000_1;
  localparam logic [17:0] ALL     = 18'h3FFFF;
  localparam logic [17:0] NO_ALU  = 18'h3FFF1;
  typedef struct {
    logic r;
    logic [5:0] op;
    logic [5:0] fn;
    logic z;
    logic rdy;
    logic [17:0] e;
    logic [17:0] care;
  } vec_t;
  vec_t vecs[$];
  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy,
                     input logic [17:0] e, input logic [17:0] care = ALL);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.e = e; v.care = care;
    vecs.push_back(v);
  endtask
  task automatic apply(input string name, input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input logic [17:0] e, input logic [17:0] care);
    @(negedge clk);
    rst = r; bus.Op = op; bus.funct = fn; bus.Zero = z; bus.MemReady = rdy;
    #1;
    n++;
    if ((act & care) !== (e & care)) begin
      fails++;
      $display("FAIL %s: got %b want %b (care %b)", name, act, e, care);
    end
  endtask
  initial begin
    rst = 1'b1; bus.Op = '0; bus.funct = '0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
    add(1, 6'b000000, 6'b100000, 0, 1, E_ZERO);
    add(0, 6'b000000, 6'b100000, 0, 1, E_FRDY);
    add(0, 6'b000000, 6'b100000, 0, 1, E_DEC);
    add(0, 6'b000000, 6'b100000, 0, 1, E_EXADD);
    add(0, 6'b000000, 6'b100000, 0, 1, E_AWB);
    add(0, 6'b100011, 6'b000000, 0, 1, E_FRDY);
    add(0, 6'b100011, 6'b000000, 0, 1, E_DEC);
    add(0, 6'b100011, 6'b000000, 0, 1, E_MADDR);
    add(0, 6'b100011, 6'b000000, 0, 0, E_MRD);
    add(0, 6'b100011, 6'b000000, 0, 0, E_MRD);
    add(0, 6'b100011, 6'b000000, 0, 0, E_MRD);
    add(0, 6'b100011, 6'b000000, 0, 1, E_MRD);
    add(0, 6'b100011, 6'b000000, 0, 1, E_MWB);
    add(0, 6'b000100, 6'b000000, 1, 1, E_FRDY);
    add(0, 6'b000100, 6'b000000, 1, 1, E_DEC);
    add(0, 6'b000100, 6'b000000, 1, 1, E_BRT);
    add(0, 6'b000101, 6'b000000, 1, 1, E_FRDY);
    add(0, 6'b000101, 6'b000000, 1, 1, E_DEC);
    add(0, 6'b000101, 6'b000000, 1, 1, E_BRN);
    add(0, 6'b001101, 6'b000000, 0, 1, E_FRDY);
    add(0, 6'b001101, 6'b000000, 0, 1, E_DEC);
    add(0, 6'b001101, 6'b000000, 0, 1, E_ORI);
    add(0, 6'b001101, 6'b000000, 0, 1, E_IWB);
    add(0, 6'b101011, 6'b000000, 0, 1, E_FRDY);
    add(0, 6'b101011, 6'b000000, 0, 1, E_DEC);
    add(0, 6'b101011, 6'b000000, 0, 1, E_MADDR);
    add(0, 6'b101011, 6'b000000, 0, 0, E_MWR);
    add(0, 6'b101011, 6'b000000, 0, 1, E_MWR);
    add(0, 6'b000010, 6'b000000, 0, 0, E_FWAIT);
    add(0, 6'b000010, 6'b000000, 0, 1, E_FRDY);
    add(0, 6'b000010, 6'b000000, 0, 1, E_DEC);
    add(0, 6'b000010, 6'b000000, 0, 1, E_JMP);
    add(0, 6'b001010, 6'b000000, 0, 1, E_FRDY);
    add(0, 6'b001010, 6'b000000, 0, 1, E_DEC);
    add(0, 6'b001010, 6'b000000, 0, 1, E_SLTI);
    add(0, 6'b001010, 6'b000000, 0, 1, E_IWB);
    add(0, 6'b100011, 6'b000000, 0, 1, E_FRDY);
    add(0, 6'b100011, 6'b000000, 0, 1, E_DEC);
    add(0, 6'b100011, 6'b000000, 0, 1, E_MADDR);
    add(1, 6'b100011, 6'b000000, 0, 0, E_ZERO);
    add(0, 6'b100011, 6'b000000, 0, 0, E_FWAIT);
    add(0, 6'b111111, 6'b000000, 0, 1, E_FRDY);
    add(0, 6'b111111, 6'b000000, 0, 1, E_DEC);
    add(0, 6'b111111, 6'b000000, 0, 1, E_TRAP);
    add(0, 6'b000000, 6'b100000, 1, 1, E_TRAP);
    add(1, 6'b000000, 6'b000111, 0, 1, E_ZERO);
    add(0, 6'b000000, 6'b000111, 0, 1, E_FRDY);
    add(0, 6'b000000, 6'b000111, 0, 1, E_DEC);
    add(0, 6'b000000, 6'b000111, 0, 1, E_EXBAD, NO_ALU);
    add(0, 6'b000000, 6'b000111, 0, 1, E_TRAP);
    add(1, 6'b000000, 6'b000000, 0, 1, E_ZERO);
    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].r, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy, vecs[i].e, vecs[i].care);
    // 15 not-ready cycles then ready on the limit cycle: the fetch completes
    apply("ready_prio_rst", 1, 6'b000000, 6'b100000, 0, 0, E_ZERO, ALL);
    for (int i = 0; i < 15; i++) apply($sformatf("ready_prio_wait%0d", i), 0, 6'b000000, 6'b100000, 0, 0, E_FWAIT, ALL);
    apply("ready_prio_fetch", 0, 6'b000000, 6'b100000, 0, 1, E_FRDY, ALL);
    apply("ready_prio_decode", 0, 6'b000000, 6'b100000, 0, 1, E_DEC, ALL);
    // 16 not-ready cycles in FETCH: timeout trap, sticky until reset
    apply("timeout_rst", 1, 6'b000000, 6'b100000, 0, 0, E_ZERO, ALL);
    for (int i = 0; i < 16; i++) apply($sformatf("timeout_wait%0d", i), 0, 6'b000000, 6'b100000, 0, 0, E_FWAIT, ALL);
    for (int i = 0; i < 4; i++) apply($sformatf("timeout_trap%0d", i), 0, 6'b101011, 6'b100000, 1, 1, E_TRAP, ALL);
    apply("trap_rst", 1, 6'b000000, 6'b100000, 0, 1, E_ZERO, ALL);
    apply("trap_exit", 0, 6'b000000, 6'b100000, 0, 1, E_FRDY, ALL);
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
